conv_addr_seq: RTL and testbench

Address sequencer for the 1-D convolution datapath, sitting directly downstream of the X/Y size register. On `start` it captures `sizeX` and `sizeY` (the lengths of vectors X and Y held in memories X and Y) and walks every product term of z[n] = Σ x[i]·y[n−i]. Each cycle it emits one read-address pair for memories X and Y, the output index n for memory Z, and accumulator framing strobes (first term / last term of each n). It runs one term per cycle with no stalls and pulses `done` when the walk finishes.

---
 rtl/conv_addr_seq.sv | 143 ++++++++++++++
 tb/tb_conv_addr_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_addr_seq.sv
// Address sequencer for 1-D convolution z[n] = sum x[i]*y[n-i].
// Emits one (i, j, n) term per cycle with accumulator framing strobes; all outputs registered.
module conv_addr_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] sizeX,
  input  logic [4:0] sizeY,
  output logic       busy,
  output logic       rd_en,
  output logic [4:0] addrX,
  output logic [4:0] addrY,
  output logic [5:0] addrZ,
  output logic       acc_clr,
  output logic       acc_last,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

  state_t     state, state_nxt;
  logic [4:0] sx, sy, sx_nxt, sy_nxt;
  logic       busy_nxt, rd_en_nxt, clr_nxt, last_nxt, done_nxt;
  logic [4:0] ax_nxt, ay_nxt;
  logic [5:0] az_nxt;
  logic [5:0] n_max, n_inc, lo_inc;
  logic       run_end;

  function automatic logic [5:0] i_hi(input logic [5:0] n, input logic [4:0] s);
    logic [5:0] lim;
    lim = {1'b0, s} - 6'd1;
    return (n < lim) ? n : lim;
  endfunction

  // Lower bound by comparison so n-(sy-1) can never wrap below zero.
  function automatic logic [5:0] i_lo(input logic [5:0] n, input logic [4:0] s);
    logic [5:0] lim;
    lim = {1'b0, s} - 6'd1;
    return (n > lim) ? (n - lim) : 6'd0;
  endfunction

  // The output registers double as the i/j/n walk counters.
  assign n_max   = {1'b0, sx} + {1'b0, sy} - 6'd2;
  assign run_end = acc_last && (addrZ == n_max);
  assign n_inc   = addrZ + 6'd1;
  assign lo_inc  = i_lo(n_inc, sy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sx       <= '0;
      sy       <= '0;
      busy     <= 1'b0;
      rd_en    <= 1'b0;
      addrX    <= '0;
      addrY    <= '0;
      addrZ    <= '0;
      acc_clr  <= 1'b0;
      acc_last <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sx       <= sx_nxt;
      sy       <= sy_nxt;
      busy     <= busy_nxt;
      rd_en    <= rd_en_nxt;
      addrX    <= ax_nxt;
      addrY    <= ay_nxt;
      addrZ    <= az_nxt;
      acc_clr  <= clr_nxt;
      acc_last <= last_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = (sx == 5'd0 || sy == 5'd0) ? FIN : RUN;
      RUN:     if (run_end) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sx_nxt    = sx;
    sy_nxt    = sy;
    busy_nxt  = busy;
    rd_en_nxt = 1'b0;
    ax_nxt    = '0;
    ay_nxt    = '0;
    az_nxt    = '0;
    clr_nxt   = 1'b0;
    last_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          busy_nxt = 1'b1;
          sx_nxt   = sizeX;
          sy_nxt   = sizeY;
        end
      end
      LOAD: begin
        if (sx == 5'd0 || sy == 5'd0) begin
          done_nxt = 1'b1;
        end else begin
          // n=0 always has exactly one term, so it is both first and last.
          rd_en_nxt = 1'b1;
          clr_nxt   = 1'b1;
          last_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (run_end) begin
          done_nxt = 1'b1;
        end else if (!acc_last) begin
          rd_en_nxt = 1'b1;
          ax_nxt    = addrX + 5'd1;
          ay_nxt    = addrY - 5'd1;
          az_nxt    = addrZ;
          last_nxt  = (({1'b0, addrX} + 6'd1) == i_hi(addrZ, sx));
        end else begin
          rd_en_nxt = 1'b1;
          az_nxt    = n_inc;
          ax_nxt    = lo_inc[4:0];
          ay_nxt    = n_inc[4:0] - lo_inc[4:0];
          clr_nxt   = 1'b1;
          last_nxt  = (lo_inc == i_hi(n_inc, sx));
        end
      end
      FIN: begin
        busy_nxt = 1'b0;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_conv_addr_seq.sv
// Directed self-checking bench for conv_addr_seq.
// Cycle numbering: cycle 1 is the cycle right after the edge that accepts start.
`timescale 1ns/1ps
module tb_conv_addr_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] sizeX = '0;
  logic [4:0] sizeY = '0;
  logic       busy, rd_en, acc_clr, acc_last, done;
  logic [4:0] addrX, addrY;
  logic [5:0] addrZ;

  int n_checks = 0;
  int n_fail   = 0;

  int q_n[$], q_i[$], q_j[$], q_c[$], q_l[$], q_cyc[$], q_done[$];
  int busy_at[1024];

  conv_addr_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sizeX(sizeX), .sizeY(sizeY),
    .busy(busy), .rd_en(rd_en), .addrX(addrX), .addrY(addrY), .addrZ(addrZ),
    .acc_clr(acc_clr), .acc_last(acc_last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic pulse_start(input int sx, input int sy, input bit hold);
    @(posedge clk);
    #1;
    sizeX = 5'(sx);
    sizeY = 5'(sy);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic capture(input int budget, input int poke);
    q_n.delete(); q_i.delete(); q_j.delete(); q_c.delete(); q_l.delete();
    q_cyc.delete(); q_done.delete();
    for (int c = 0; c < 1024; c++) busy_at[c] = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c < 1024) busy_at[c] = int'(busy);
      if (rd_en) begin
        q_n.push_back(int'(addrZ)); q_i.push_back(int'(addrX)); q_j.push_back(int'(addrY));
        q_c.push_back(int'(acc_clr)); q_l.push_back(int'(acc_last)); q_cyc.push_back(c);
      end
      if (done) q_done.push_back(c);
      if (c == poke) begin
        start = 1'b1;
        sizeX = 5'd7;
      end else if (c == poke + 1) begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, rd_en, done, acc_clr, acc_last} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, rd_en, done, acc_clr, acc_last});
    end
    n_checks++;
    if ({addrX, addrY, addrZ} !== 16'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h expected 0000", {addrX, addrY, addrZ});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_3x2();
    int en[6] = '{0, 1, 1, 2, 2, 3};
    int ei[6] = '{0, 0, 1, 1, 2, 2};
    int ej[6] = '{0, 1, 0, 1, 0, 1};
    int ec[6] = '{1, 1, 0, 1, 0, 1};
    int el[6] = '{1, 0, 1, 0, 1, 1};
    pulse_start(3, 2, 1'b0);
    capture(12, -1);
    n_checks++;
    if (q_n.size() != 6) begin n_fail++; $display("FAIL 3x2_count: got %0d expected 6", q_n.size()); end
    for (int t = 0; t < 6 && t < q_n.size(); t++) begin
      n_checks++;
      if ({q_n[t], q_i[t], q_j[t]} !== {en[t], ei[t], ej[t]}) begin
        n_fail++; $display("FAIL 3x2_term%0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                           t, q_n[t], q_i[t], q_j[t], en[t], ei[t], ej[t]);
      end
      n_checks++;
      if ({q_c[t], q_l[t], q_cyc[t]} !== {ec[t], el[t], t + 2}) begin
        n_fail++; $display("FAIL 3x2_strobe%0d: got clr=%0d last=%0d cyc=%0d expected clr=%0d last=%0d cyc=%0d",
                           t, q_c[t], q_l[t], q_cyc[t], ec[t], el[t], t + 2);
      end
    end
    n_checks++;
    if (q_done.size() != 1 || q_done[0] != 8) begin
      n_fail++; $display("FAIL 3x2_done: got count=%0d first=%0d expected count=1 first=8", q_done.size(), q_done[0]);
    end
    n_checks++;
    if ({busy_at[1], busy_at[8], busy_at[9]} !== {32'd1, 32'd1, 32'd0}) begin
      n_fail++; $display("FAIL 3x2_busy: got %0d%0d%0d expected 110", busy_at[1], busy_at[8], busy_at[9]);
    end
  endtask

  task automatic test_1x1();
    pulse_start(1, 1, 1'b0);
    capture(6, -1);
    n_checks++;
    if (q_n.size() != 1 || q_cyc[0] != 2 || {q_n[0], q_i[0], q_j[0]} !== {32'd0, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL 1x1_term: got count=%0d cyc=%0d (%0d,%0d,%0d) expected count=1 cyc=2 (0,0,0)",
                         q_n.size(), q_cyc[0], q_n[0], q_i[0], q_j[0]);
    end
    n_checks++;
    if (q_c[0] != 1 || q_l[0] != 1) begin
      n_fail++; $display("FAIL 1x1_strobes: got clr=%0d last=%0d expected 1 1", q_c[0], q_l[0]);
    end
    n_checks++;
    if (q_done.size() != 1 || q_done[0] != 3) begin
      n_fail++; $display("FAIL 1x1_done: got count=%0d first=%0d expected 1 at 3", q_done.size(), q_done[0]);
    end
  endtask

  task automatic test_zero_size();
    pulse_start(0, 5, 1'b0);
    capture(6, -1);
    n_checks++;
    if (q_n.size() != 0) begin n_fail++; $display("FAIL zero_rd_en: got %0d terms expected 0", q_n.size()); end
    n_checks++;
    if (q_done.size() != 1 || q_done[0] != 2) begin
      n_fail++; $display("FAIL zero_done: got count=%0d first=%0d expected 1 at 2", q_done.size(), q_done[0]);
    end
    n_checks++;
    if ({busy_at[1], busy_at[2], busy_at[3]} !== {32'd1, 32'd1, 32'd0}) begin
      n_fail++; $display("FAIL zero_busy: got %0d%0d%0d expected 110", busy_at[1], busy_at[2], busy_at[3]);
    end
  endtask

  task automatic test_31x31();
    bit seen[31][31];
    int bad_sum = 0, dup = 0, bad_ord = 0, bad_clr = 0, bad_last = 0, nclr = 0, nlast = 0;
    int k;
    for (int a = 0; a < 31; a++) for (int b = 0; b < 31; b++) seen[a][b] = 1'b0;
    pulse_start(31, 31, 1'b0);
    capture(968, -1);
    k = q_n.size();
    for (int t = 0; t < k; t++) begin
      if (q_i[t] > 30 || q_j[t] > 30 || q_i[t] + q_j[t] != q_n[t]) bad_sum++;
      else if (seen[q_i[t]][q_j[t]]) dup++;
      else seen[q_i[t]][q_j[t]] = 1'b1;
      if (t > 0 && !((q_n[t] == q_n[t-1] && q_i[t] == q_i[t-1] + 1) || q_n[t] == q_n[t-1] + 1)) bad_ord++;
      if (q_c[t] != int'(t == 0 || q_n[t] != q_n[t-1])) bad_clr++;
      if (q_l[t] != int'(t == k - 1 || q_n[t] != q_n[t+1])) bad_last++;
      nclr += q_c[t];
      nlast += q_l[t];
    end
    n_checks++;
    if (k != 961) begin n_fail++; $display("FAIL 31x31_count: got %0d expected 961", k); end
    n_checks++;
    if (bad_sum != 0 || dup != 0) begin
      n_fail++; $display("FAIL 31x31_pairs: got bad_sum=%0d dup=%0d expected 0 0", bad_sum, dup);
    end
    n_checks++;
    if (bad_ord != 0) begin n_fail++; $display("FAIL 31x31_order: got %0d errors expected 0", bad_ord); end
    n_checks++;
    if (bad_clr != 0 || bad_last != 0 || nclr != 61 || nlast != 61) begin
      n_fail++; $display("FAIL 31x31_strobes: got bad_clr=%0d bad_last=%0d nclr=%0d nlast=%0d expected 0 0 61 61",
                         bad_clr, bad_last, nclr, nlast);
    end
    n_checks++;
    if (k == 0 || {q_n[k-1], q_i[k-1], q_j[k-1]} !== {32'd60, 32'd30, 32'd30}) begin
      n_fail++; $display("FAIL 31x31_last: got (%0d,%0d,%0d) expected (60,30,30)",
                         (k > 0) ? q_n[k-1] : -1, (k > 0) ? q_i[k-1] : -1, (k > 0) ? q_j[k-1] : -1);
    end
    n_checks++;
    if (q_done.size() != 1 || q_done[0] != 963) begin
      n_fail++; $display("FAIL 31x31_done: got count=%0d first=%0d expected 1 at 963", q_done.size(), q_done[0]);
    end
  endtask

  task automatic test_ignored_inputs();
    int k;
    pulse_start(4, 4, 1'b0);
    capture(24, 5);
    k = q_n.size();
    n_checks++;
    if (k != 16) begin n_fail++; $display("FAIL ign_count: got %0d expected 16", k); end
    n_checks++;
    if (k == 0 || {q_n[k-1], q_i[k-1], q_j[k-1]} !== {32'd6, 32'd3, 32'd3}) begin
      n_fail++; $display("FAIL ign_last: got (%0d,%0d,%0d) expected (6,3,3)",
                         (k > 0) ? q_n[k-1] : -1, (k > 0) ? q_i[k-1] : -1, (k > 0) ? q_j[k-1] : -1);
    end
    n_checks++;
    if (q_done.size() != 1 || q_done[0] != 18) begin
      n_fail++; $display("FAIL ign_done: got count=%0d first=%0d expected 1 at 18", q_done.size(), q_done[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    int en[6] = '{0, 1, 1, 2, 2, 3};
    int ei[6] = '{0, 0, 1, 0, 1, 1};
    int ej[6] = '{0, 1, 0, 2, 1, 2};
    int dcnt = 0;
    pulse_start(5, 5, 1'b0);
    repeat (6) @(negedge clk);
    n_checks++;
    if ({rd_en, addrZ, addrX, addrY} !== {1'b1, 6'd2, 5'd1, 5'd1}) begin
      n_fail++; $display("FAIL mid_term5: got rd_en=%b (%0d,%0d,%0d) expected 1 (2,1,1)", rd_en, addrZ, addrX, addrY);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, rd_en, done, acc_clr, acc_last, addrX, addrY, addrZ} !== 21'h0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h expected 0",
                         {busy, rd_en, done, acc_clr, acc_last, addrX, addrY, addrZ});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    n_checks++;
    if (dcnt != 0) begin n_fail++; $display("FAIL mid_no_done: got %0d active cycles expected 0", dcnt); end
    pulse_start(2, 3, 1'b0);
    capture(12, -1);
    n_checks++;
    if (q_n.size() != 6) begin n_fail++; $display("FAIL 2x3_count: got %0d expected 6", q_n.size()); end
    for (int t = 0; t < 6 && t < q_n.size(); t++) begin
      n_checks++;
      if ({q_n[t], q_i[t], q_j[t]} !== {en[t], ei[t], ej[t]}) begin
        n_fail++; $display("FAIL 2x3_term%0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                           t, q_n[t], q_i[t], q_j[t], en[t], ei[t], ej[t]);
      end
    end
    n_checks++;
    if (q_done.size() != 1 || q_done[0] != 8) begin
      n_fail++; $display("FAIL 2x3_done: got count=%0d first=%0d expected 1 at 8", q_done.size(), q_done[0]);
    end
  endtask

  task automatic test_back_to_back();
    pulse_start(1, 1, 1'b1);
    capture(11, -1);
    start = 1'b0;
    n_checks++;
    if (q_cyc.size() != 3 || q_cyc[0] != 2 || q_cyc[1] != 6 || q_cyc[2] != 10) begin
      n_fail++; $display("FAIL b2b_terms: got count=%0d cyc=%0d,%0d,%0d expected 3 at 2,6,10",
                         q_cyc.size(), q_cyc[0], q_cyc[1], q_cyc[2]);
    end
    n_checks++;
    if (q_done.size() != 3 || q_done[0] != 3 || q_done[1] != 7 || q_done[2] != 11) begin
      n_fail++; $display("FAIL b2b_done: got count=%0d cyc=%0d,%0d,%0d expected 3 at 3,7,11",
                         q_done.size(), q_done[0], q_done[1], q_done[2]);
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_3x2();
    test_1x1();
    test_zero_size();
    test_31x31();
    test_ignored_inputs();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
